jk_flop_bank: RTL and testbench

- Parametrised bank of WIDTH JK flip-flops with per-bit J/K inputs.
- Adds global enable, synchronous clear/preset, change-flag outputs, and built-in up/down counter modes formed from JK toggle cells.
- Successor to the single-bit JK cell; used as a general state register and small event counter in control datapaths.

---
 rtl/jk_flop_bank.sv | 91 +++++++++
 tb/tb_jk_flop_bank.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/jk_flop_bank.sv
// jk_flop_bank: WIDTH JK flip-flops with per-bit J/K inputs, a global enable,
// synchronous clear/preset, per-bit change flags and up/down counter modes
// built from JK toggle cells. q, changed and tc are registered; qn = ~q.
module jk_flop_bank #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             preset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] changed,
  output logic             tc
);

  typedef enum logic [1:0] {
    M_JK   = 2'b00,
    M_UP   = 2'b01,
    M_DN   = 2'b10,
    M_HOLD = 2'b11
  } mode_e;

  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic             all_ones;
  logic             all_zeros;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;

  // Toggle enables for the counter: bit i toggles when every lower bit is
  // one (up) or zero (down); the final running terms flag the wrap points.
  always_comb begin
    up_t      = '0;
    dn_t      = '0;
    all_ones  = 1'b1;
    all_zeros = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      up_t[i]   = all_ones;
      dn_t[i]   = all_zeros;
      all_ones  = all_ones & q[i];
      all_zeros = all_zeros & ~q[i];
    end
  end

  // Next state by priority: clear > preset > enable gate > mode.
  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
    if (clear) begin
      q_next = '0;
    end else if (preset) begin
      q_next = '1;
    end else if (en) begin
      case (mode_e'(mode))
        M_JK: q_next = (j & ~q) | (~k & q);
        // A single-bit counter reports terminal count on every counting edge.
        M_UP: begin
          q_next  = q ^ up_t;
          tc_next = (WIDTH == 1) ? 1'b1 : all_ones;
        end
        M_DN: begin
          q_next  = q ^ dn_t;
          tc_next = (WIDTH == 1) ? 1'b1 : all_zeros;
        end
        default: q_next = q;
      endcase
    end
  end

  // State, change flags and terminal-count pulse; reset dominates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= RST_VAL;
      changed <= '0;
      tc      <= 1'b0;
    end else begin
      q       <= q_next;
      changed <= q_next ^ q;
      tc      <= tc_next;
    end
  end

  assign qn = ~q;

endmodule

// File: tb/tb_jk_flop_bank.sv
// Scoreboard bench for jk_flop_bank: three instances (WIDTH 4, 1 and 8 with
// RST_VAL 8'hA5) share stimulus; a reference model pushes expected outputs
// per edge and a monitor pops and compares them after each rising edge.
module tb_jk_flop_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, clr = 1'b0, pre = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] jv = '0, kv = '0;

  logic [3:0] q4, qn4, ch4;
  logic       tc4;
  logic [0:0] q1, qn1, ch1;
  logic       tc1;
  logic [7:0] q8, qn8, ch8;
  logic       tc8;

  jk_flop_bank #(.WIDTH(4)) d4 (
    .clk(clk), .reset(rst_n), .en(en), .clear(clr), .preset(pre), .mode(mode),
    .j(jv[3:0]), .k(kv[3:0]), .q(q4), .qn(qn4), .changed(ch4), .tc(tc4));

  jk_flop_bank #(.WIDTH(1)) d1 (
    .clk(clk), .reset(rst_n), .en(en), .clear(clr), .preset(pre), .mode(mode),
    .j(jv[0:0]), .k(kv[0:0]), .q(q1), .qn(qn1), .changed(ch1), .tc(tc1));

  jk_flop_bank #(.WIDTH(8), .RST_VAL(8'hA5)) d8 (
    .clk(clk), .reset(rst_n), .en(en), .clear(clr), .preset(pre), .mode(mode),
    .j(jv), .k(kv), .q(q8), .qn(qn8), .changed(ch8), .tc(tc8));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned q;
    int unsigned ch;
    bit          tc;
  } exp_t;

  exp_t        sb0[$], sb1[$], sb2[$];
  int unsigned mdl[3]  = '{0, 0, 8'hA5};
  int unsigned wid[3]  = '{4, 1, 8};
  int unsigned rval[3] = '{0, 0, 8'hA5};
  int          total = 0;
  int          bad = 0;

  function automatic void chk(string name, int unsigned act, int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: one edge of instance idx computed with plain arithmetic.
  function automatic void mstep(int idx);
    int unsigned w    = wid[idx];
    int unsigned mask = (1 << w) - 1;
    int unsigned cur  = mdl[idx];
    int unsigned nxt  = cur;
    exp_t        e;
    e.tc = 1'b0;
    if (!rst_n) begin
      nxt  = rval[idx];
      e.ch = 0;
    end else begin
      if (clr) nxt = 0;
      else if (pre) nxt = mask;
      else if (en) begin
        case (mode)
          2'b00: for (int b = 0; b < int'(w); b++) begin
            case ({jv[b], kv[b]})
              2'b01: nxt[b] = 1'b0;
              2'b10: nxt[b] = 1'b1;
              2'b11: nxt[b] = ~cur[b];
              default: ;
            endcase
          end
          2'b01: begin
            nxt  = (cur + 1) & mask;
            e.tc = (w == 1) || (cur == mask);
          end
          2'b10: begin
            nxt  = (cur - 1) & mask;
            e.tc = (w == 1) || (cur == 0);
          end
          default: ;
        endcase
      end
      e.ch = nxt ^ cur;
    end
    e.q = nxt;
    mdl[idx] = nxt;
    case (idx)
      0: sb0.push_back(e);
      1: sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endfunction

  task automatic step();
    for (int i = 0; i < 3; i++) mstep(i);
    @(posedge clk);
    #2;
  endtask

  // Monitor: every rising edge yields one output set per instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        chk("w4.q", q4, e.q);
        chk("w4.qn", qn4, ~e.q & 4'hF);
        chk("w4.changed", ch4, e.ch);
        chk("w4.tc", tc4, e.tc);
      end
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        chk("w1.q", q1, e.q);
        chk("w1.qn", qn1, ~e.q & 1);
        chk("w1.changed", ch1, e.ch);
        chk("w1.tc", tc1, e.tc);
      end
      if (sb2.size() > 0) begin
        e = sb2.pop_front();
        chk("w8.q", q8, e.q);
        chk("w8.qn", qn8, ~e.q & 8'hFF);
        chk("w8.changed", ch8, e.ch);
        chk("w8.tc", tc8, e.tc);
      end
    end
  end

  initial begin
    // reset, then JK set/reset, toggle, hold
    step();
    step();
    rst_n = 1'b1; en = 1'b1; mode = 2'b00;
    jv = 8'h0A; kv = 8'h05; step();
    jv = 8'h0F; kv = 8'h0F; step();
    jv = 8'h00; kv = 8'h00; step();
    // synchronous controls ignore en; en=0 holds
    en = 1'b0; pre = 1'b1; step();
    clr = 1'b1; step();
    clr = 1'b0; pre = 1'b0; jv = 8'hFF; kv = 8'hFF; step();
    // count up through the wrap
    en = 1'b1; mode = 2'b01;
    for (int i = 0; i < 16; i++) step();
    // count down from zero, then reverse direction mid-count
    clr = 1'b1; step();
    clr = 1'b0; mode = 2'b10;
    for (int i = 0; i < 3; i++) step();
    mode = 2'b01; step();
    // asynchronous reset between edges
    clr = 1'b1; step();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) step();
    #3 rst_n = 1'b0;
    #1;
    chk("async.q4", q4, 0);
    chk("async.tc4", tc4, 0);
    chk("async.ch4", ch4, 0);
    chk("async.q8", q8, 8'hA5);
    chk("async.tc8", tc8, 0);
    chk("async.ch8", ch8, 0);
    for (int i = 0; i < 3; i++) mdl[i] = rval[i];
    @(posedge clk); #2;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    // wrap from all ones in every width
    pre = 1'b1; step();
    pre = 1'b0; step();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 60) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      pre   = ($urandom_range(0, 15) == 0);
      en    = ($urandom_range(0, 4) != 0);
      mode  = 2'($urandom_range(0, 3));
      jv    = 8'($urandom);
      kv    = 8'($urandom);
      step();
    end
    rst_n = 1'b1; clr = 1'b0; pre = 1'b0; en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("drain", sb0.size() + sb1.size() + sb2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
